// File: rtl/bus_decoder_fsm.sv
`default_nettype none
// ============================================================================
// Module      : bus_decoder_fsm
// Description : Address decoder / req-ready sequencer between the core data
//               port and N_SLV slaves. Optional hung-slave timeout is enabled
//               by defining BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_decoder_fsm #(
    parameter int                      ADDR_W  = 32,
    parameter int                      DATA_W  = 32,
    parameter int                      N_SLV   = 5,
    parameter logic [N_SLV*ADDR_W-1:0] BASE    = {32'h8, 32'h3, 32'h2, 32'h1, 32'h0},
    parameter logic [N_SLV*ADDR_W-1:0] LIMIT   = {32'hFFFFFFFF, 32'h7, 32'h2, 32'h1, 32'h0},
    parameter int                      TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_req,
    input  logic                    m_we,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [N_SLV-1:0]        s_cs,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV-1:0]        s_ready,
    input  logic [N_SLV*DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [N_SLV-1:0]    w_match;
    logic [N_SLV-1:0]    w_dec_cs;
    logic                w_dec_hit;
    logic                w_sel_ready;
    logic [DATA_W-1:0]   w_sel_rdata;

    if (N_SLV < 1 || N_SLV > 16 || TIMEOUT < 1) begin : g_bad_params
        $error("bus_decoder_fsm: N_SLV must be 1..16 and TIMEOUT >= 1");
    end

    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_match
        assign w_match[gi] = (m_addr >= BASE[gi*ADDR_W +: ADDR_W]) &&
                             (m_addr <= LIMIT[gi*ADDR_W +: ADDR_W]);
    end

    // Isolating the lowest set bit gives lowest-index priority on overlaps.
    assign w_dec_cs    = w_match & (~w_match + N_SLV'(1));
    assign w_dec_hit   = |w_match;
    assign w_sel_ready = |(s_ready & s_cs);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (s_cs[i]) begin
                w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int                c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               w_timeout;

    // The counter would reach TIMEOUT on this edge.
    assign w_timeout = (r_wait_cnt >= c_CNT_END);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            s_cs    <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
`ifdef BUS_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (m_req) begin
                        if (w_dec_hit) begin
                            s_we    <= m_we;
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                            s_cs    <= w_dec_cs;
                            r_state <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end else begin
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        m_ready <= 1'b1;
                        m_rdata <= s_we ? '0 : w_sel_rdata;
                        s_cs    <= '0;
                        r_state <= ST_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (w_timeout) begin
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                        s_cs    <= '0;
                        r_state <= ST_RESP;
                    end else if (r_wait_cnt != c_CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_decoder_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_decoder_fsm
// Description : Directed bench for bus_decoder_fsm with a per-cycle timeline
//               model; adapts to BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_decoder_fsm;

    localparam int NS    = 5;
    localparam int TO    = 4;
    localparam int MAXC  = 2048;
    localparam int NEVER = 200;

    // Gap at 8..0x1F, slaves 1 and 2 overlap at address 1.
    localparam logic [NS*32-1:0] P_BASE  = {32'h20, 32'h3, 32'h1, 32'h1, 32'h0};
    localparam logic [NS*32-1:0] P_LIMIT = {32'hFFFFFFFF, 32'h7, 32'h2, 32'h1, 32'h0};

    logic [31:0] mdl_base  [NS] = '{32'h0, 32'h1, 32'h1, 32'h3, 32'h20};
    logic [31:0] mdl_limit [NS] = '{32'h0, 32'h1, 32'h2, 32'h7, 32'hFFFFFFFF};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_req = 1'b0;
    logic          m_we = 1'b0;
    logic [31:0]   m_addr = '0;
    logic [31:0]   m_wdata = '0;
    logic          m_ready;
    logic          m_err;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_cs;
    logic          s_we;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [NS-1:0] s_ready = '0;
    logic [NS*32-1:0] s_rdata;
    logic [31:0]   slv_data [NS];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    logic [NS-1:0] e_cs [MAXC];
    bit            e_ready [MAXC];
    bit            e_err [MAXC];
    bit            e_bus [MAXC];
    bit            e_we [MAXC];
    logic [31:0]   e_rdata [MAXC];
    logic [31:0]   e_addr [MAXC];
    logic [31:0]   e_wdata [MAXC];
    logic [NS-1:0] sched [MAXC];

    logic [NS-1:0] act_cs [MAXC];
    logic          act_ready [MAXC];
    logic          act_err [MAXC];
    logic          act_we [MAXC];
    logic [31:0]   act_rdata [MAXC];
    logic [31:0]   act_wdata [MAXC];

    for (genvar g = 0; g < NS; g++) begin : g_rdata
        assign s_rdata[g*32 +: 32] = slv_data[g];
    end

    bus_decoder_fsm #(
        .ADDR_W (32),
        .DATA_W (32),
        .N_SLV  (NS),
        .BASE   (P_BASE),
        .LIMIT  (P_LIMIT),
        .TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_ready(m_ready),
        .m_err  (m_err),
        .m_rdata(m_rdata),
        .s_cs   (s_cs),
        .s_we   (s_we),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_ready(s_ready),
        .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= mdl_base[i] && a <= mdl_limit[i]) return i;
        end
        return -1;
    endfunction

    function automatic void clear_from(input int c);
        for (int k = c; k < MAXC; k++) begin
            e_cs[k] = '0; e_ready[k] = 0; e_err[k] = 0; e_bus[k] = 0; e_we[k] = 0;
            e_rdata[k] = '0; e_addr[k] = '0; e_wdata[k] = '0; sched[k] = '0;
        end
    endfunction

    // Slave side: ready strobes follow the planned timeline.
    always @(negedge clk) begin
        if (cyc < MAXC) s_ready = sched[cyc];
    end

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            act_cs[cyc] = s_cs; act_ready[cyc] = m_ready; act_err[cyc] = m_err;
            act_we[cyc] = s_we; act_rdata[cyc] = m_rdata; act_wdata[cyc] = s_wdata;
            if (chk_en) begin
                check("m_ready", m_ready, e_ready[cyc]);
                check("s_cs", s_cs, e_cs[cyc]);
                if (e_ready[cyc]) begin
                    check("m_err", m_err, e_err[cyc]);
                    check("m_rdata", m_rdata, e_rdata[cyc]);
                end
                if (e_bus[cyc]) begin
                    check("s_we", s_we, e_we[cyc]);
                    check("s_addr", s_addr, e_addr[cyc]);
                    check("s_wdata", s_wdata, e_wdata[cyc]);
                end
            end
        end
    end

    // Called at a negedge: request is sampled on the next rising edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input bit hold, input bit noise, input bit scramble,
                         input int stop_after, output int t0, output int tr);
        int sel;
        int eff;
        bit err_to;
        logic [NS-1:0] oh;
        t0 = cyc;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
        sel = model_decode(addr);
        if (sel < 0) begin
            tr = t0 + 1;
            e_ready[tr] = 1; e_err[tr] = 1; e_rdata[tr] = '0;
        end else begin
            oh = NS'(1) << sel;
            eff = waits;
            err_to = 0;
`ifdef BUS_TIMEOUT_EN
            if (waits > TO - 1) begin
                eff = TO - 1;
                err_to = 1;
            end
`endif
            for (int k = t0 + 1; k <= t0 + 1 + eff && k < MAXC; k++) begin
                e_cs[k] = oh; e_bus[k] = 1; e_we[k] = we; e_addr[k] = addr; e_wdata[k] = wd;
                sched[k] = noise ? ~oh : '0;
            end
            if (t0 + 1 + waits < MAXC) sched[t0 + 1 + waits] = sched[t0 + 1 + waits] | oh;
            tr = t0 + 2 + eff;
            if (tr < MAXC) begin
                e_ready[tr] = 1; e_err[tr] = err_to;
                e_rdata[tr] = (we || err_to) ? 32'h0 : slv_data[sel];
            end
        end
        while (cyc < tr && cyc < t0 + stop_after) begin
            @(negedge clk);
            if (scramble && cyc == t0 + 1) m_addr = ~addr;
        end
        if (scramble) m_addr = addr;
        if (cyc >= tr && !hold) m_req = 1'b0;
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        #2 rst_n = 1'b0;
        m_req = 1'b0;
        #1;
        check("async reset s_cs", s_cs, 64'h0);
        check("async reset m_ready", m_ready, 64'h0);
        clear_from(c + 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tr, t1, tr1, pulses;
        logic [31:0] tbl_addr [7];
        int          tbl_wait [7];
        tbl_addr = '{32'h1, 32'h2, 32'h3, 32'h7, 32'h1F, 32'h20, 32'hFFFFFFFF};
        tbl_wait = '{0, 1, 2, 0, 0, 1, 0};
        clear_from(0);
        slv_data[0] = 32'hA5;       slv_data[1] = 32'h1111_0001;
        slv_data[2] = 32'h2222_0002; slv_data[3] = 32'h3333_0003;
        slv_data[4] = 32'hCAFE_0100;

        @(negedge clk);
        check("reset m_ready", m_ready, 64'h0);
        check("reset m_err", m_err, 64'h0);
        check("reset s_cs", s_cs, 64'h0);
        check("reset s_we", s_we, 64'h0);
        check("reset m_rdata", m_rdata, 64'h0);
        check("reset s_addr", s_addr, 64'h0);
        check("reset s_wdata", s_wdata, 64'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Zero-wait read of slave 0
        issue(1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 1000, t0, tr);
        #1;
        check("rd0 cs cycle1", act_cs[t0+1], 64'b00001);
        check("rd0 ready cycle2", act_ready[t0+2], 64'h1);
        check("rd0 err", act_err[t0+2], 64'h0);
        check("rd0 rdata", act_rdata[t0+2], 64'hA5);

        // Write to slave 3 with 3 waits, noisy unselected readies, moving address
        @(negedge clk);
        issue(1'b1, 32'h5, 32'h3C, 3, 0, 1, 1, 1000, t0, tr);
        #1;
        check("wr cs first", act_cs[t0+1], 64'b01000);
        check("wr cs last", act_cs[t0+4], 64'b01000);
        check("wr cs cleared", act_cs[t0+5], 64'h0);
        check("wr no early ready", act_ready[t0+4], 64'h0);
        check("wr ready cycle5", act_ready[t0+5], 64'h1);
        check("wr rdata zero", act_rdata[t0+5], 64'h0);
        check("wr s_we", act_we[t0+2], 64'h1);
        check("wr s_wdata", act_wdata[t0+3], 64'h3C);

        // Back-to-back reads of slave 4 with m_req held
        @(negedge clk);
        issue(1'b0, 32'h100, 32'h0, 0, 1, 0, 0, 1000, t0, tr);
        @(negedge clk);
        issue(1'b0, 32'h100, 32'h0, 0, 0, 0, 0, 1000, t1, tr1);
        #1;
        check("b2b first ready", act_ready[t0+2], 64'h1);
        check("b2b gap", act_ready[t0+3] | act_ready[t0+4], 64'h0);
        check("b2b second ready", act_ready[t0+5], 64'h1);
        check("b2b cs", act_cs[t0+4], 64'b10000);
        check("b2b rdata", act_rdata[t0+5], 64'hCAFE0100);

        // Unmapped address in the gap
        @(negedge clk);
        issue(1'b0, 32'h10, 32'h0, 0, 0, 0, 0, 1000, t0, tr);
        #1;
        check("unmapped ready", act_ready[t0+1], 64'h1);
        check("unmapped err", act_err[t0+1], 64'h1);
        check("unmapped cs", act_cs[t0+1], 64'h0);
        check("unmapped rdata", act_rdata[t0+1], 64'h0);

        // Region edges and overlap priority
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            issue(1'b0, tbl_addr[i], 32'h0, tbl_wait[i], 0, 0, 0, 1000, t0, tr);
            #1;
            if (i == 0) check("overlap lowest index", act_cs[t0+1], 64'b00010);
        end

        // Ready arriving on the last allowed wait cycle
        @(negedge clk);
        issue(1'b0, 32'h2, 32'h0, TO - 1, 0, 1, 0, 1000, t0, tr);
        #1;
        check("late ready", act_ready[t0+5], 64'h1);
        check("late ready err", act_err[t0+5], 64'h0);
        check("late ready rdata", act_rdata[t0+5], 64'h2222_0002);

        // Reset in the middle of ACCESS, then a normal access
        @(negedge clk);
        issue(1'b0, 32'h40, 32'h0, 10, 0, 0, 0, 3, t0, tr);
        do_reset();
        #1;
        check("abort cs before reset", act_cs[t0+3], 64'b10000);
        check("abort cs after reset", act_cs[t0+4], 64'h0);
        pulses = 0;
        for (int k = t0 + 1; k <= t0 + 5; k++) pulses += int'(act_ready[k]);
        check("abort no ready", pulses, 64'h0);
        @(negedge clk);
        issue(1'b0, 32'h0, 32'h0, 1, 0, 0, 0, 1000, t0, tr);
        #1;
        check("post-reset ready", act_ready[t0+3], 64'h1);
        check("post-reset rdata", act_rdata[t0+3], 64'hA5);

        // Slave 2 never answers
        @(negedge clk);
`ifdef BUS_TIMEOUT_EN
        issue(1'b0, 32'h2, 32'h0, NEVER, 0, 0, 0, 1000, t0, tr);
        #1;
        check("timeout cs held", act_cs[t0+4], 64'b00100);
        check("timeout cs cleared", act_cs[t0+5], 64'h0);
        check("timeout ready", act_ready[t0+5], 64'h1);
        check("timeout err", act_err[t0+5], 64'h1);
`else
        issue(1'b0, 32'h2, 32'h0, NEVER, 0, 0, 0, 100, t0, tr);
        #1;
        pulses = 0;
        for (int k = t0 + 1; k <= t0 + 100; k++) pulses += int'(act_ready[k]);
        check("hung no ready in 100", pulses, 64'h0);
        check("hung cs held", act_cs[t0+100], 64'b00100);
        do_reset();
`endif
        @(negedge clk);
        issue(1'b1, 32'h3, 32'h77, 0, 0, 0, 0, 1000, t0, tr);
        #1;
        check("final write ready", act_ready[t0+2], 64'h1);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
